uart_frame_tx: RTL

//   Parametrised UART response-frame transmitter for the host link.

---
 rtl/uart_frame_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_tx.sv
// UART response-frame transmitter: HEADER, payload bytes, optional CRC-8, TAIL, with an idle gap after every byte.
// Latency: first start bit START_DELAY clocks after acceptance; frame_done START_DELAY+NB*(10*BAUD_DIV+GAP_CYCLES)+1 clocks after acceptance.
// Backpressure: none; frame_start while busy (or in the frame_done cycle) is dropped and reported by a one-cycle frame_drop.
// Build option: define UART_FRAME_CRC_EN to insert the CRC-8 byte (poly 0x07) before TAIL.
module uart_frame_tx #(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          UART_BPS    = 115200,
    parameter int          PAYLOAD_MAX = 8,
    parameter logic [7:0]  HEADER      = 8'h80,
    parameter logic [7:0]  TAIL        = 8'h55,
    parameter int          START_DELAY = 16,
    parameter logic [15:0] GAP_CYCLES  = 16'h01E0
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic [PAYLOAD_MAX*8-1:0] payload,
    input  logic [7:0]               payload_len,
    output logic                     uart_txd,
    output logic                     tx_busy,
    output logic                     frame_done,
    output logic                     frame_drop
);

    localparam int          BAUD_DIV   = CLK_FREQ / UART_BPS;
    localparam int          BW         = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [15:0] DELAY_LAST = 16'(START_DELAY - 1);
    localparam logic [15:0] GAP_LAST   = GAP_CYCLES - 16'd1;
    localparam logic [7:0]  LEN_MAX    = 8'(PAYLOAD_MAX);
`ifdef UART_FRAME_CRC_EN
    localparam logic [8:0]  TRAILER_BYTES = 9'd2;
`else
    localparam logic [8:0]  TRAILER_BYTES = 9'd1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              dly_cnt;
    logic [BW-1:0]            baud_cnt;
    logic [3:0]               bit_cnt;
    logic [15:0]              gap_cnt;
    logic [9:0]               shreg;
    logic [PAYLOAD_MAX*8-1:0] pay_q;
    logic [7:0]               len_q;
    logic [8:0]               byte_idx;
    logic                     tail_q;
`ifdef UART_FRAME_CRC_EN
    logic [7:0]               crc_q;
`endif

    logic       idle_ready;
    logic       accept;
    logic       delay_end;
    logic       baud_end;
    logic       bit_end;
    logic       gap_end;
    logic [8:0] last_idx;
    logic       is_payload;
    logic [7:0] cur_byte;

`ifdef UART_FRAME_CRC_EN
    // Fold one byte into the CRC, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] r;
        r = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`endif

    // The frame_done cycle is already IDLE but must not accept a new frame.
    assign idle_ready = (state_q == S_IDLE) && !frame_done;
    assign accept     = idle_ready && frame_start;
    assign delay_end  = (dly_cnt == DELAY_LAST);
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign bit_end    = baud_end && (bit_cnt == 4'd9);
    assign gap_end    = (gap_cnt == GAP_LAST);
    assign last_idx   = {1'b0, len_q} + TRAILER_BYTES;
    assign is_payload = (byte_idx != 9'd0) && (byte_idx <= {1'b0, len_q});

    // Byte for the current index; payload bytes come from the low end of the shifting payload copy.
    always_comb begin
        cur_byte = TAIL;
        if (byte_idx == 9'd0) begin
            cur_byte = HEADER;
        end else if (is_payload) begin
            cur_byte = pay_q[7:0];
        end
`ifdef UART_FRAME_CRC_EN
        else if (byte_idx == ({1'b0, len_q} + 9'd1)) begin
            cur_byte = crc_q;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and line/busy outputs; the LOAD cycle is already the first clock of the start bit.
    always_comb begin
        state_d  = state_q;
        uart_txd = 1'b1;
        tx_busy  = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (accept) state_d = S_DELAY;
            S_DELAY: if (delay_end) state_d = S_LOAD;
            S_LOAD: begin
                uart_txd = 1'b0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                uart_txd = shreg[0];
                if (bit_end) begin
                    if (GAP_CYCLES == 16'd0) begin
                        state_d = tail_q ? S_DONE : S_LOAD;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP:   if (gap_end) state_d = tail_q ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: frame latch, byte sequencing, bit/gap timing and CRC accumulation.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            dly_cnt  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shreg    <= '1;
            pay_q    <= '0;
            len_q    <= '0;
            byte_idx <= '0;
            tail_q   <= 1'b0;
`ifdef UART_FRAME_CRC_EN
            crc_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pay_q    <= payload;
                        len_q    <= (payload_len > LEN_MAX) ? LEN_MAX : payload_len;
                        byte_idx <= '0;
                        dly_cnt  <= '0;
`ifdef UART_FRAME_CRC_EN
                        crc_q    <= '0;
`endif
                    end
                end
                S_DELAY: dly_cnt <= dly_cnt + 16'd1;
                S_LOAD: begin
                    shreg    <= {1'b1, cur_byte, 1'b0};
                    baud_cnt <= BW'(1);
                    bit_cnt  <= '0;
                    byte_idx <= byte_idx + 9'd1;
                    tail_q   <= (byte_idx == last_idx);
                    if (is_payload) begin
                        pay_q <= pay_q >> 8;
`ifdef UART_FRAME_CRC_EN
                        crc_q <= crc8_byte(crc_q, pay_q[7:0]);
`endif
                    end
                end
                S_SHIFT: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b1, shreg[9:1]};
                        if (bit_end) begin
                            gap_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // One-cycle completion and refusal pulses.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_done <= (state_q == S_DONE);
            frame_drop <= frame_start && !idle_ready;
        end
    end

endmodule
